// File: rtl/nand_addr_seq_pkg.sv
// nand_addr_pkg: shared mode encodings, FSM states and sizing helpers for the NAND address sequencer.
package nand_addr_pkg;
  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_COL  = 2'b01;
  localparam logic [1:0] MODE_ROW  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;
  localparam int MAX_BYTES = 4;
  typedef enum logic [2:0] {IDLE, SETUP, WE_LO, WE_HI, DONE} state_t;
  function automatic int cnt_w(input int v);
    return v < 2 ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/nand_addr_seq_we_timer.sv
// nand_we_timer: loadable down-counter that flags the last cycle of the WE_LO and WE_HI phases.
module nand_we_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          lo,
  input  logic          hi,
  output logic          lo_end,
  output logic          hi_end
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign lo_end = lo && cnt == '0;
  assign hi_end = hi && cnt == '0;
endmodule

// File: rtl/nand_addr_seq.sv
// nand_addr_seq: serialises latched column/row address bytes onto the flash bus with ALE/WE# timing.
// Optional row-range check enabled by defining NAND_ADDR_ROW_CHECK_EN.
module nand_addr_seq
  import nand_addr_pkg::*;
#(
  parameter int          COL_BYTES   = 2,
  parameter int          ROW_BYTES   = 3,
  parameter int          WE_LOW_CYC  = 2,
  parameter int          WE_HIGH_CYC = 2,
  parameter logic [31:0] ROW_MAX     = 32'h00FF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [8*COL_BYTES-1:0] addr_column,
  input  logic [8*ROW_BYTES-1:0] addr_row,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   ale,
  output logic                   we_n,
  output logic [7:0]             addr_data
);
  localparam int N  = COL_BYTES + ROW_BYTES;
  localparam int TW = cnt_w(WE_LOW_CYC > WE_HIGH_CYC ? WE_LOW_CYC : WE_HIGH_CYC);
  state_t state, state_nx;
  logic [16*MAX_BYTES-1:0] cat;
  logic [2:0] idx, last;
  logic bad, accept, load, lo_end, hi_end, active;
  logic [TW-1:0] load_val;
`ifdef NAND_ADDR_ROW_CHECK_EN
  assign bad = mode == MODE_RSVD || (mode != MODE_COL && 32'(addr_row) > ROW_MAX);
`else
  assign bad = mode == MODE_RSVD;
`endif
  assign accept = state == IDLE && start && !bad;
  // Row-only mode starts indexing past the column bytes of the {row,col} image.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err   <= 1'b0;
      idx   <= '0;
      last  <= '0;
      cat   <= '0;
    end else begin
      state <= state_nx;
      err   <= state == IDLE && start && bad;
      if (accept) begin
        cat  <= (16*MAX_BYTES)'({addr_row, addr_column});
        idx  <= mode == MODE_ROW ? 3'(COL_BYTES) : 3'd0;
        last <= mode == MODE_COL ? 3'(COL_BYTES - 1) : 3'(N - 1);
      end else if (hi_end && idx != last) idx <= idx + 3'd1;
    end
  end
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = TW'(WE_LOW_CYC - 1);
    unique case (state)
      IDLE:  if (accept) state_nx = SETUP;
      SETUP: begin
        state_nx = WE_LO;
        load     = 1'b1;
      end
      WE_LO: if (lo_end) begin
        state_nx = WE_HI;
        load     = 1'b1;
        load_val = TW'(WE_HIGH_CYC - 1);
      end
      WE_HI: if (hi_end) begin
        state_nx = idx == last ? DONE : WE_LO;
        load     = idx != last;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  nand_we_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .lo       (state == WE_LO),
    .hi       (state == WE_HI),
    .lo_end   (lo_end),
    .hi_end   (hi_end)
  );
  assign active    = state == SETUP || state == WE_LO || state == WE_HI;
  assign ale       = active;
  assign we_n      = state != WE_LO;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign addr_data = active ? cat[{idx, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_nand_addr_seq.sv
// tb_nand_addr_seq: directed self-checking bench for nand_addr_seq with default timing parameters.
module tb_nand_addr_seq;
`ifdef NAND_ADDR_ROW_CHECK_EN
  localparam logic [31:0] RMAX = 32'h0000_FFFF;
`else
  localparam logic [31:0] RMAX = 32'h00FF_FFFF;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [15:0] addr_column = '0;
  logic [23:0] addr_row = '0;
  logic busy, done, err, ale, we_n;
  logic [7:0] addr_data;
  int tests = 0, fails = 0;

  nand_addr_seq #(.ROW_MAX(RMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .addr_column(addr_column), .addr_row(addr_row),
    .busy(busy), .done(done), .err(err), .ale(ale), .we_n(we_n), .addr_data(addr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    chk("reset ale", int'(ale), 0);
    chk("reset we_n", int'(we_n), 1);
    chk("reset addr_data", int'(addr_data), 0);
    rst = 1'b0;
  endtask

  // Runs one accepted sequence; optionally re-pulses start at cycle restart_at.
  task automatic run(input string nm, input logic [1:0] m, input logic [15:0] c, input logic [23:0] r,
                     input int nb, input logic [39:0] exp, input int done_at, input int restart_at);
    int pulses, ndone, done_cyc, ale_first, ale_last, busy_drop, errs;
    logic prev_we;
    logic [7:0] got [8];
    pulses = 0; ndone = 0; done_cyc = -1; ale_first = -1; ale_last = -1; busy_drop = -1; errs = 0;
    prev_we = 1'b1;
    @(negedge clk);
    mode = m; addr_column = c; addr_row = r; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; addr_column = ~c; addr_row = ~r;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (we_n && !prev_we && pulses < 8) begin
        got[pulses] = addr_data;
        pulses++;
      end
      prev_we = we_n;
      if (done) begin ndone++; done_cyc = cyc; end
      if (ale) begin
        if (ale_first < 0) ale_first = cyc;
        ale_last = cyc;
      end
      if (err) errs++;
      if (!busy && busy_drop < 0) busy_drop = cyc;
      if (cyc == restart_at) begin
        mode = 2'b01; addr_column = 16'h5A5A; addr_row = 24'h3C3C3C; start = 1'b1;
      end
      if (cyc == restart_at + 1) start = 1'b0;
    end
    chk({nm, " pulses"}, pulses, nb);
    for (int k = 0; k < nb && k < 8; k++) chk($sformatf("%s byte%0d", nm, k), int'(got[k]), int'(exp[8*k +: 8]));
    chk({nm, " done cycle"}, done_cyc, done_at);
    chk({nm, " done count"}, ndone, 1);
    chk({nm, " err"}, errs, 0);
    chk({nm, " ale first"}, ale_first, 1);
    chk({nm, " ale last"}, ale_last, done_at - 1);
    chk({nm, " busy drop"}, busy_drop, done_at + 1);
  endtask

  task automatic test_full();
    run("full", 2'b00, 16'h1234, 24'hABCDEF, 5, 40'hABCDEF1234, 22, -5);
  endtask

  task automatic test_col_row();
    run("col", 2'b01, 16'h00FF, 24'hABCDEF, 2, 40'h00FF, 10, -5);
    run("row", 2'b10, 16'h00FF, 24'hABCDEF, 3, 40'hABCDEF, 14, -5);
  endtask

  task automatic test_reject(input string nm, input logic [1:0] m, input logic [23:0] r);
    int act;
    act = 0;
    @(negedge clk);
    mode = m; addr_column = 16'h1234; addr_row = r; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({nm, " err c1"}, int'(err), 1);
    for (int cyc = 2; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (busy || ale || !we_n || err) act++;
    end
    chk({nm, " quiet"}, act, 0);
  endtask

  task automatic test_back_to_back();
    run("restart", 2'b00, 16'h1234, 24'hABCDEF, 5, 40'hABCDEF1234, 22, 10);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    mode = 2'b00; addr_column = 16'h1234; addr_row = 24'hABCDEF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid we_n low", int'(we_n), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid we_n", int'(we_n), 1);
    chk("mid ale", int'(ale), 0);
    chk("mid busy", int'(busy), 0);
    chk("mid addr_data", int'(addr_data), 0);
    rst = 1'b0;
    run("after rst", 2'b00, 16'h1234, 24'hABCDEF, 5, 40'hABCDEF1234, 22, -5);
  endtask

  initial begin
    test_reset();
    test_full();
    test_col_row();
    test_reject("rsvd", 2'b11, 24'hABCDEF);
    test_back_to_back();
    test_mid_reset();
`ifdef NAND_ADDR_ROW_CHECK_EN
    test_reject("rowmax", 2'b00, 24'h010000);
    run("row ok", 2'b00, 16'h1234, 24'h00FFFF, 5, 40'h00FFFF1234, 22, -5);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nand_addr_seq.md
Name: nand_addr_seq

Overview:
- Parametrised NAND address-cycle sequencer; generalised successor to the fixed 2-column/3-row address byte mux.
- Latches column and row addresses on a start handshake and serialises them LSB-first onto the 8-bit flash bus.
- Generates ALE and WE# with programmable low/high widths; supports full, column-only and row-only address modes.
- Sits between the command FSM (start/done) and the flash I/O pad mux.

Parameters:
- COL_BYTES, 2, number of column address bytes (1..4)
- ROW_BYTES, 3, number of row address bytes (1..4)
- WE_LOW_CYC, 2, clk cycles WE# held low per byte (1..15)
- WE_HIGH_CYC, 2, clk cycles WE# held high per byte (1..15)
- ROW_MAX, 24'hFFFFFF, highest legal row address (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; accepted only in IDLE
- mode  in  2  00 full (col+row), 01 column only, 10 row only, 11 reserved
- addr_column  in  8*COL_BYTES  column address
- addr_row  in  8*ROW_BYTES  row address
- busy  out  1  high from the cycle after acceptance through DONE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse
- ale  out  1  address latch enable to flash
- we_n  out  1  write enable to flash, active low
- addr_data  out  8  address byte on the flash bus

Behaviour:
- Reset: one clk cycle with rst=1 forces state IDLE, busy=0, done=0, err=0, ale=0, we_n=1, addr_data=8'h00, and clears all counters. Reset mid-sequence aborts at the next edge; no partial byte completes.
- States: IDLE, SETUP, WE_LO, WE_HI, DONE.
- IDLE: start=1 with mode 00/01/10 latches mode and both addresses, then moves to SETUP.
  - start with mode 11 stays in IDLE and pulses err for one cycle next edge.
  - start while not in IDLE is ignored, with no err.
- Byte list: full = column bytes then row bytes; column-only = column bytes; row-only = row bytes. Each field is sent LSB byte first.
  - N = COL_BYTES+ROW_BYTES, COL_BYTES, or ROW_BYTES respectively.
- SETUP: 1 cycle. ale=1, busy=1, we_n=1, addr_data = byte 0.
- WE_LO: we_n=0 for WE_LOW_CYC cycles, then WE_HI.
- WE_HI: we_n=1 for WE_HIGH_CYC cycles. The flash latches on the we_n rising edge.
  - addr_data stays stable through WE_LO and WE_HI of a byte.
  - After the last WE_HI cycle: if more bytes remain, the byte index increments, addr_data updates, and the FSM returns to WE_LO. Otherwise it goes to DONE.
- DONE: 1 cycle. done=1, ale=0, addr_data=8'h00, busy=1. Then IDLE with busy=0.
- Latency: start sampled at edge 0 → SETUP at cycle 1 → DONE at cycle 2+N*(WE_LOW_CYC+WE_HIGH_CYC).
- Outside SETUP/WE_LO/WE_HI: ale=0, we_n=1, addr_data=8'h00.
- Input addresses may change after acceptance without affecting the sequence in flight.
- start asserted in the DONE cycle is ignored; it is accepted only in the following IDLE cycle.

Optional Feature:
- Macro: NAND_ADDR_ROW_CHECK_EN.
- Defined: on acceptance with mode 00/10 and addr_row > ROW_MAX, the block stays in IDLE, pulses err for one cycle, and issues no ALE/WE# activity.
- Undefined: ROW_MAX is ignored, no row comparator is synthesised, and err is driven only by mode 11.

Decomposition:
- Package nand_addr_pkg: mode encodings (MODE_FULL, MODE_COL, MODE_ROW, MODE_RSVD), state enum, max byte-count constant (4), width helper for the timing counter.
- One natural sub-module, nand_we_timer: loadable down-counter producing the WE_LO/WE_HI phase-end strobes.
- Byte selection stays inline as an indexed mux over the latched concatenation.

Test Plan:
- Defaults, mode 00, col=16'h1234, row=24'hABCDEF, start at cycle 0:
  - bytes 34,12,EF,CD,AB on the we_n rising edges;
  - ale=1 for cycles 1–21;
  - done at cycle 22;
  - busy drops at cycle 23.
- mode 01, col=16'h00FF: 2 WE# pulses (FF,00), done at cycle 10. mode 10 with the same row: 3 pulses (EF,CD,AB), done at cycle 14.
- mode 11 start → err=1 at cycle 1, busy/ale stay 0, we_n stays 1.
- start re-pulsed during WE_LO of byte 2 with different addresses → original sequence unchanged, no err, single done.
- rst asserted during byte 3 WE_LO → next cycle we_n=1, ale=0, busy=0, addr_data=00; a new start then completes normally.
- With NAND_ADDR_ROW_CHECK_EN, ROW_MAX=24'h00FFFF, row=24'h010000, mode 00 → err pulse, no ALE/WE# activity. row=24'h00FFFF → normal 5-byte sequence.
